// File: rtl/audio_mixer_n.sv
// -----------------------------------------------------------------------------
// audio_mixer_n
//
// Parametrised N-channel audio mixer. When sample_en is seen in IDLE, the
// pulse bit, volume, bipolar mode and mute mask of every channel are captured.
// The captured channels are then summed one per clock into a wide signed
// accumulator. The sum is clamped to the signed OUT_W range and registered.
//
// Ports
//   clk         mixer clock
//   RES_n       asynchronous active-low reset; aborts any mix in flight
//   sample_en   one-cycle strobe requesting a new output sample
//   ch_pulse    tone output bit per channel
//   ch_vol      volume per channel, channel i at [i*VOL_W +: VOL_W]
//   ch_bipolar  1: a low pulse contributes -vol*STEP; 0: it contributes 0
//   ch_mask     1: channel muted
//   clr_ovr     clears the sticky overrun flag (a new overrun event wins)
//   audio_out   signed mixed sample, held between updates
//   out_valid   one-cycle pulse when audio_out updates
//   busy        high while a mix is in progress (ACC or SAT)
//   overrun     sticky; a sample_en arrived while a mix was in progress
// -----------------------------------------------------------------------------
module audio_mixer_n #(
    parameter int          NUM_CH = 4,
    parameter int          VOL_W  = 4,
    parameter int          OUT_W  = 16,
    parameter logic [15:0] STEP   = 16'h03FF
) (
    input  logic                      clk,
    input  logic                      RES_n,
    input  logic                      sample_en,
    input  logic [NUM_CH-1:0]         ch_pulse,
    input  logic [NUM_CH*VOL_W-1:0]   ch_vol,
    input  logic [NUM_CH-1:0]         ch_bipolar,
    input  logic [NUM_CH-1:0]         ch_mask,
    input  logic                      clr_ovr,
    output logic [OUT_W-1:0]          audio_out,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      overrun
);

    // Index width, accumulator width and width of one vol*STEP product.
    localparam int IW = $clog2(NUM_CH);
    localparam int AW = OUT_W + $clog2(NUM_CH) + VOL_W + 1;
    localparam int PW = VOL_W + 16;

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CH - 1);

    // Clamp bounds sign-extended to the accumulator width.
    localparam logic signed [AW-1:0] SAT_MAX =
        {{(AW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN =
        {{(AW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_SAT  = 2'd2
    } state_e;

    // Clamp the wide sum into the signed OUT_W range; values exactly on a
    // bound fall through the last branch unchanged.
    function automatic logic [OUT_W-1:0] saturate(input logic signed [AW-1:0] value);
        logic [OUT_W-1:0] result;
        if (value > SAT_MAX) begin
            result = {1'b0, {(OUT_W - 1){1'b1}}};
        end else if (value < SAT_MIN) begin
            result = {1'b1, {(OUT_W - 1){1'b0}}};
        end else begin
            result = value[OUT_W-1:0];
        end
        return result;
    endfunction

    state_e                    state_q,     state_d;
    logic signed [AW-1:0]      acc_q,       acc_d;
    logic [IW-1:0]             idx_q,       idx_d;
    logic [NUM_CH-1:0]         pulse_q,     pulse_d;
    logic [NUM_CH*VOL_W-1:0]   vol_q,       vol_d;
    logic [NUM_CH-1:0]         bipolar_q,   bipolar_d;
    logic [NUM_CH-1:0]         mask_q,      mask_d;
    logic [OUT_W-1:0]          audio_out_q, audio_out_d;
    logic                      out_valid_q, out_valid_d;
    logic                      overrun_q,   overrun_d;

    logic [VOL_W-1:0]          vol_sel_s;
    logic [PW-1:0]             mag_s;
    logic signed [AW-1:0]      mag_ext_s;
    logic signed [AW-1:0]      term_s;

    // Signed contribution of the channel currently selected by idx_q.
    always_comb begin
        vol_sel_s = vol_q[idx_q*VOL_W +: VOL_W];
        // Unsigned product; sign is applied only after zero-extension.
        mag_s     = {{16{1'b0}}, vol_sel_s} * {{VOL_W{1'b0}}, STEP};
        mag_ext_s = {{(AW - PW){1'b0}}, mag_s};
        if (mask_q[idx_q]) begin
            term_s = {AW{1'b0}};
        end else if (pulse_q[idx_q]) begin
            term_s = mag_ext_s;
        end else if (bipolar_q[idx_q]) begin
            term_s = {AW{1'b0}} - mag_ext_s;
        end else begin
            term_s = {AW{1'b0}};
        end
    end

    // Next-state, datapath and flag logic for the IDLE/ACC/SAT sequencer.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        pulse_d     = pulse_q;
        vol_d       = vol_q;
        bipolar_d   = bipolar_q;
        mask_d      = mask_q;
        audio_out_d = audio_out_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (sample_en) begin
                    pulse_d   = ch_pulse;
                    vol_d     = ch_vol;
                    bipolar_d = ch_bipolar;
                    mask_d    = ch_mask;
                    acc_d     = {AW{1'b0}};
                    idx_d     = {IW{1'b0}};
                    state_d   = ST_ACC;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_ACC: begin
                acc_d = acc_q + term_s;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_SAT;
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_SAT: begin
                audio_out_d = saturate(acc_q);
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A strobe during a mix is dropped; flag it. Setting beats clearing.
        if (sample_en && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end else if (clr_ovr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State and datapath registers; RES_n discards any mix in progress.
    always_ff @(posedge clk or negedge RES_n) begin
        if (!RES_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= {AW{1'b0}};
            idx_q       <= {IW{1'b0}};
            pulse_q     <= {NUM_CH{1'b0}};
            vol_q       <= {(NUM_CH * VOL_W){1'b0}};
            bipolar_q   <= {NUM_CH{1'b0}};
            mask_q      <= {NUM_CH{1'b0}};
            audio_out_q <= {OUT_W{1'b0}};
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            pulse_q     <= pulse_d;
            vol_q       <= vol_d;
            bipolar_q   <= bipolar_d;
            mask_q      <= mask_d;
            audio_out_q <= audio_out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign audio_out = audio_out_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
